// File: rtl/bclk_training_ctrl_pkg.sv
// rtl/bclk_training_ctrl_pkg.sv - shared DDR PHY training definitions
// Holds the training FSM state encoding, the BCLK training patterns,
// the delay-line tap width and small helpers used by the BCLK trainer.
package bclk_training_ctrl_pkg;

  localparam int TAP_W = 8;

  localparam logic [7:0] BCLK_PAT_A = 8'h55;
  localparam logic [7:0] BCLK_PAT_B = 8'hAA;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLEAR,
    SETTLE,
    SAMPLE,
    STEP,
    C_LOAD,
    C_SETTLE,
    C_MOVE,
    C_WAIT,
    DONE,
    ERR
  } train_state_e;

  // A BCLK sample is good when it shows either phase of the 0101 pattern.
  function automatic logic is_bclk_pattern(input logic [7:0] data);
    return (data == BCLK_PAT_A) || (data == BCLK_PAT_B);
  endfunction

  // Floor midpoint of an inclusive tap window, computed without overflow.
  function automatic logic [TAP_W-1:0] window_center(input logic [TAP_W-1:0] first,
                                                     input logic [TAP_W-1:0] last);
    return first + ((last - first) >> 1);
  endfunction

endpackage

// File: rtl/training_wait_cnt.sv
// rtl/training_wait_cnt.sv - loadable down-counter for training wait states
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load          : load load_val this cycle (takes priority over counting)
//   load_val      : value loaded; a wait of N cycles loads N-1
//   zero          : counter has reached 0 (the last cycle of the wait)
module training_wait_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bclk_training_ctrl.sv
// rtl/bclk_training_ctrl.sv - BCLK delay-line eye training controller
// Sweeps the BCLK receive delay line from tap 0 upward, finds the first
// contiguous window of taps that sample the 0101 pattern cleanly, then
// reloads the delay line and steps it to the centre of that window.
// Ports:
//   FAB_CLK, ARST                        : clock, asynchronous active-high reset
//   TRAIN_START                          : one-cycle start request (idle/done/err only)
//   EYE_MONITOR_EARLY_0/LATE_0, RX_DATA_0: per-tap sampling inputs
//   DELAY_LINE_OUT_OF_RANGE_0            : delay line hit its limit
//   DELAY_LINE_LOAD_0/MOVE_0/DIRECTION_0 : delay-line control
//   EYE_MONITOR_CLEAR_FLAGS_0            : clears eye-monitor flags before each tap
//   TRAIN_BUSY/DONE/ERR                  : status
//   TAP_CENTER, WINDOW_WIDTH             : result of the last run
module bclk_training_ctrl
  import bclk_training_ctrl_pkg::*;
#(
  parameter int MAX_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST,
  input  logic             TRAIN_START,
  input  logic             EYE_MONITOR_EARLY_0,
  input  logic             EYE_MONITOR_LATE_0,
  input  logic [7:0]       RX_DATA_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0,
  output logic             DELAY_LINE_LOAD_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  output logic             EYE_MONITOR_CLEAR_FLAGS_0,
  output logic             TRAIN_BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_ERR,
  output logic [TAP_W-1:0] TAP_CENTER,
  output logic [TAP_W-1:0] WINDOW_WIDTH
);

  localparam int               CNT_W       = 16;
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(MAX_TAPS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  train_state_e     state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] first_q, first_d;
  logic [TAP_W-1:0] last_q, last_d;
  logic             found_q, found_d;
  logic [TAP_W-1:0] center_q, center_d;
  logic [TAP_W-1:0] width_q, width_d;
  logic [TAP_W-1:0] moves_q, moves_d;
  logic [CNT_W-1:0] samp_q, samp_d;
  logic             pass_q, pass_d;
  logic             oor_q, oor_d;
  logic             dir_q, dir_d;

  logic             wait_load;
  logic             wait_zero;
  logic             sample_ok;
  logic             pass_now;
  logic             oor_any;
  logic [TAP_W-1:0] first_n;
  logic [TAP_W-1:0] last_n;
  logic             found_n;

  training_wait_cnt #(
    .W(CNT_W)
  ) u_wait_cnt (
    .clk      (FAB_CLK),
    .rst      (ARST),
    .load     (wait_load),
    .load_val (SETTLE_LD),
    .zero     (wait_zero)
  );

  assign sample_ok = !EYE_MONITOR_EARLY_0 && !EYE_MONITOR_LATE_0 && is_bclk_pattern(RX_DATA_0);
  // pass_q carries the AND of all earlier sample cycles at this tap.
  assign pass_now  = pass_q && sample_ok;
  // Out-of-range is sticky from one STEP to the next so a short pulse is not missed.
  assign oor_any   = oor_q || DELAY_LINE_OUT_OF_RANGE_0;

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    first_d   = first_q;
    last_d    = last_q;
    found_d   = found_q;
    center_d  = center_q;
    width_d   = width_q;
    moves_d   = moves_q;
    samp_d    = samp_q;
    pass_d    = pass_q;
    oor_d     = oor_any;
    dir_d     = dir_q;
    wait_load = 1'b0;
    first_n   = first_q;
    last_n    = last_q;
    found_n   = found_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (TRAIN_START) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        tap_d   = '0;
        first_d = '0;
        last_d  = '0;
        found_d = 1'b0;
        oor_d   = 1'b0;
        // Direction is raised here, well ahead of the first MOVE, and never dropped.
        dir_d   = 1'b1;
        state_d = CLEAR;
      end
      CLEAR: begin
        wait_load = 1'b1;
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (wait_zero) begin
          samp_d  = '0;
          pass_d  = 1'b1;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (samp_q != SAMPLE_LAST) begin
          samp_d = samp_q + 1'b1;
          pass_d = pass_now;
        end else begin
          if (pass_now) begin
            if (!found_q) begin
              first_n = tap_q;
              found_n = 1'b1;
            end
            last_n = tap_q;
          end
          first_d = first_n;
          last_d  = last_n;
          found_d = found_n;
          // Results are taken from the updated window so they are valid in C_LOAD.
          if ((!pass_now && found_q) || ((tap_q == LAST_TAP || oor_any) && found_n)) begin
            center_d = window_center(first_n, last_n);
            width_d  = last_n - first_n + 1'b1;
            state_d  = C_LOAD;
          end else if (tap_q == LAST_TAP || oor_any) begin
            center_d = '0;
            width_d  = '0;
            state_d  = ERR;
          end else begin
            state_d = STEP;
          end
        end
      end
      STEP: begin
        tap_d   = tap_q + 1'b1;
        oor_d   = 1'b0;
        state_d = CLEAR;
      end
      C_LOAD: begin
        moves_d   = '0;
        wait_load = 1'b1;
        state_d   = C_SETTLE;
      end
      C_SETTLE: begin
        if (wait_zero) begin
          state_d = (center_q == '0) ? DONE : C_MOVE;
        end
      end
      C_MOVE: begin
        moves_d   = moves_q + 1'b1;
        wait_load = 1'b1;
        state_d   = C_WAIT;
      end
      C_WAIT: begin
        if (wait_zero) begin
          state_d = (moves_q == center_q) ? DONE : C_MOVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
      found_q  <= 1'b0;
      center_q <= '0;
      width_q  <= '0;
      moves_q  <= '0;
      samp_q   <= '0;
      pass_q   <= 1'b0;
      oor_q    <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      first_q  <= first_d;
      last_q   <= last_d;
      found_q  <= found_d;
      center_q <= center_d;
      width_q  <= width_d;
      moves_q  <= moves_d;
      samp_q   <= samp_d;
      pass_q   <= pass_d;
      oor_q    <= oor_d;
      dir_q    <= dir_d;
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  assign DELAY_LINE_LOAD_0         = (state_q == LOAD) || (state_q == C_LOAD);
  assign DELAY_LINE_MOVE_0         = (state_q == STEP) || (state_q == C_MOVE);
  assign DELAY_LINE_DIRECTION_0    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS_0 = (state_q == CLEAR);
  assign TRAIN_BUSY                = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign TRAIN_DONE                = (state_q == DONE);
  assign TRAIN_ERR                 = (state_q == ERR);
  assign TAP_CENTER                = center_q;
  assign WINDOW_WIDTH              = width_q;

endmodule

// File: tb/tb_bclk_training_ctrl.sv
// tb/tb_bclk_training_ctrl.sv - self-checking bench for bclk_training_ctrl
module tb_bclk_training_ctrl;

  localparam int MAX_TAPS = 128;

  logic       clk = 1'b0;
  logic       ARST = 1'b1;
  logic       TRAIN_START = 1'b0;
  logic       early = 1'b0;
  logic       late = 1'b0;
  logic [7:0] rx = 8'h55;
  logic       oor = 1'b0;
  logic       dl_load, dl_move, dl_dir, clr_flags;
  logic       busy, done, err;
  logic [7:0] tap_center, win_width;

  bclk_training_ctrl #(
    .MAX_TAPS      (MAX_TAPS),
    .SETTLE_CYCLES (8),
    .SAMPLE_CYCLES (4)
  ) dut (
    .FAB_CLK                   (clk),
    .ARST                      (ARST),
    .TRAIN_START               (TRAIN_START),
    .EYE_MONITOR_EARLY_0       (early),
    .EYE_MONITOR_LATE_0        (late),
    .RX_DATA_0                 (rx),
    .DELAY_LINE_OUT_OF_RANGE_0 (oor),
    .DELAY_LINE_LOAD_0         (dl_load),
    .DELAY_LINE_MOVE_0         (dl_move),
    .DELAY_LINE_DIRECTION_0    (dl_dir),
    .EYE_MONITOR_CLEAR_FLAGS_0 (clr_flags),
    .TRAIN_BUSY                (busy),
    .TRAIN_DONE                (done),
    .TRAIN_ERR                 (err),
    .TAP_CENTER                (tap_center),
    .WINDOW_WIDTH              (win_width)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment: window definition and delay-line position.
  int win_lo = -1, win_hi = -1, oor_tap = -1, glitch_tap = -1;
  int tb_tap = 0;
  int clr_age = 0;
  bit toggle = 1'b0;

  // Observations for the current run.
  int loads = 0, sweep_moves = 0, ctr_moves = 0;
  int exp_center = 0, exp_width = 0, prev_center = 0, prev_width = 0;
  bit quiet = 1'b1;
  logic prev_dir = 1'b0, prev_move = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: walk taps upward by the training rules on the effective pass map.
  task automatic model(input int lo, input int hi, input int oor_at, input int glitch,
                       output int m_err, output int m_center, output int m_width,
                       output int m_sweep);
    int first, last;
    bit found, stop, pass;
    first = 0; last = 0; found = 0; stop = 0; m_sweep = 0;
    for (int t = 0; t < MAX_TAPS && !stop; t++) begin
      pass = (t >= lo) && (t <= hi) && (t != glitch);
      if (pass) begin
        if (!found) first = t;
        last  = t;
        found = 1;
      end else if (found) begin
        stop = 1;
      end
      if (!stop) begin
        if (t == MAX_TAPS - 1 || (oor_at >= 0 && t >= oor_at)) stop = 1;
        else m_sweep++;
      end
    end
    m_err    = found ? 0 : 1;
    m_center = found ? first + (last - first) / 2 : 0;
    m_width  = found ? last - first + 1 : 0;
  endtask

  // Delay line and eye-monitor behaviour driven from the tap position.
  initial begin
    forever begin
      @(negedge clk);
      if (dl_load) tb_tap = 0;
      else if (dl_move) tb_tap = dl_dir ? tb_tap + 1 : tb_tap - 1;
      if (clr_flags) clr_age = 0;
      else clr_age++;
      toggle = ~toggle;
      early = 1'b0;
      late  = 1'b0;
      rx    = toggle ? 8'h55 : 8'hAA;
      if (!(tb_tap >= win_lo && tb_tap <= win_hi)) begin
        case (tb_tap % 3)
          0:       late = 1'b1;
          1:       early = 1'b1;
          default: rx = 8'h5A;
        endcase
      end
      // Second SAMPLE cycle after the flag clear: CLEAR=0, SETTLE=1..8, SAMPLE=9..12.
      if (tb_tap == glitch_tap && clr_age == 10) rx = 8'h5D;
      oor = (oor_tap >= 0 && tb_tap >= oor_tap);
    end
  end

  // Per-cycle compare against the run-level expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (ARST) begin
        prev_dir  = 1'b0;
        prev_move = 1'b0;
      end else begin
        check("move_load_excl", int'(dl_move && dl_load), 0);
        if (dl_move) begin
          check("dir_at_move", int'(dl_dir), 1);
          check("dir_before_move", int'(prev_dir), 1);
        end
        if (prev_move) check("dir_after_move", int'(dl_dir), 1);
        check("status_onehot", int'(busy) + int'(done) + int'(err) <= 1 ? 1 : 0, 1);
        if (err) begin
          check("err_center", int'(tap_center), 0);
          check("err_width", int'(win_width), 0);
        end
        if (done) begin
          check("done_center", int'(tap_center), exp_center);
          check("done_width", int'(win_width), exp_width);
        end
        if (dl_load) loads++;
        if (dl_move) begin
          if (loads >= 2) ctr_moves++;
          else sweep_moves++;
        end
        if (busy && loads < 2) begin
          check("hold_center", int'(tap_center), prev_center);
          check("hold_width", int'(win_width), prev_width);
        end
        if (quiet) begin
          check("quiet_idle", int'({busy, done, err, dl_load, dl_move, clr_flags}), 0);
        end
        prev_dir  = dl_dir;
        prev_move = dl_move;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, int'({dl_load, dl_move, dl_dir, clr_flags, busy, done, err}), 0);
    check({name, "_center"}, int'(tap_center), 0);
    check({name, "_width"}, int'(win_width), 0);
  endtask

  task automatic start_run(input int lo, input int hi, input int oor_at, input int glitch,
                           input int e_center, input int e_width);
    @(negedge clk);
    quiet      = 1'b0;
    win_lo     = lo;
    win_hi     = hi;
    oor_tap    = oor_at;
    glitch_tap = glitch;
    loads = 0; sweep_moves = 0; ctr_moves = 0;
    TRAIN_START = 1'b1;
    @(negedge clk);
    TRAIN_START = 1'b0;
    exp_center  = e_center;
    exp_width   = e_width;
  endtask

  task automatic run_case(input string name, input int lo, input int hi, input int oor_at,
                          input int glitch, input bit restart, input int lit_err,
                          input int lit_center, input int lit_width, input int lit_sweep);
    int m_err, m_center, m_width, m_sweep, cyc;
    model(lo, hi, oor_at, glitch, m_err, m_center, m_width, m_sweep);
    check({name, "_model_err"}, m_err, lit_err);
    check({name, "_model_center"}, m_center, lit_center);
    check({name, "_model_width"}, m_width, lit_width);
    check({name, "_model_sweep"}, m_sweep, lit_sweep);
    start_run(lo, hi, oor_at, glitch, m_center, m_width);
    cyc = 0;
    while (!(done || err) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      TRAIN_START = restart && (cyc == 20);
      if (restart && cyc == 20) check({name, "_busy_at_restart"}, int'(busy), 1);
    end
    TRAIN_START = 1'b0;
    check({name, "_finished"}, cyc < 6000 ? 1 : 0, 1);
    @(negedge clk);
    check({name, "_done"}, int'(done), 1 - m_err);
    check({name, "_err"}, int'(err), m_err);
    check({name, "_center"}, int'(tap_center), m_center);
    check({name, "_width"}, int'(win_width), m_width);
    check({name, "_center_lit"}, int'(tap_center), lit_center);
    check({name, "_width_lit"}, int'(win_width), lit_width);
    check({name, "_sweep_moves"}, sweep_moves, m_sweep);
    check({name, "_ctr_moves"}, ctr_moves, m_center);
    check({name, "_loads"}, loads, m_err ? 1 : 2);
    if (m_err == 0) check({name, "_final_tap"}, tb_tap, m_center);
    prev_center = m_center;
    prev_width  = m_width;
  endtask

  task automatic reset_in_center_wait();
    int cyc;
    start_run(20, 40, -1, -1, 30, 21);
    cyc = 0;
    while (ctr_moves < 5 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_cwait", cyc < 6000 ? 1 : 0, 1);
    @(negedge clk);
    #1 ARST = 1'b1;
    #1 check_all_zero("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_held");
    ARST = 1'b0;
    prev_center = 0;
    prev_width  = 0;
    quiet = 1'b1;
    repeat (60) @(negedge clk);
    check_all_zero("rst_no_resume");
  endtask

  initial begin
    ARST = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    ARST = 1'b0;
    @(negedge clk);
    check_all_zero("reset_release");

    run_case("win20_40", 20, 40, -1, -1, 1'b0, 0, 30, 21, 41);
    run_case("nopass", -1, -1, -1, -1, 1'b0, 1, 0, 0, 127);
    run_case("win0_0", 0, 0, -1, -1, 1'b0, 0, 0, 1, 1);
    run_case("oor110", 100, 120, 110, -1, 1'b0, 0, 105, 11, 110);
    run_case("glitch5", 3, 9, -1, 5, 1'b1, 0, 3, 2, 5);
    reset_in_center_wait();
    run_case("after_rst", 0, 0, -1, -1, 1'b0, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
